// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] LP_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/loader_wr_stage.sv
// One-stage registered byte-write port toward instruction memory.
module loader_wr_stage #(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_data,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [7:0]        o_wdata
);

    logic              r_we_p1;
    logic [ADDR_W-1:0] r_waddr_p1;
    logic [7:0]        r_wdata_p1;

    // stage p1: we pulses for exactly one cycle per accepted payload byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we_p1    <= 1'b0;
            r_waddr_p1 <= '0;
            r_wdata_p1 <= '0;
        end else begin
            r_we_p1 <= i_vld;
            if (i_vld) begin
                r_waddr_p1 <= i_addr;
                r_wdata_p1 <= i_data;
            end
        end
    end

    assign o_we    = r_we_p1;
    assign o_waddr = r_waddr_p1;
    assign o_wdata = r_wdata_p1;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: SYNC, LEN_LO, LEN_HI, payload, CSUM -> imem byte writes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 20,
    parameter int                MEM_BYTES = 100,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]        SYNC_BYTE = LP_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [15:0] LP_MAX_LEN = 16'(MEM_BYTES);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [15:0]       r_count;
    logic [7:0]        r_sum;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_core_hold;
    logic              w_xfer;
    logic              w_wr_vld;
    logic [15:0]       w_len;
    logic              w_len_bad;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;

    assign w_xfer    = in_valid && in_ready;
    assign w_len     = {in_data, r_len_lo};
    assign w_len_bad = (w_len > LP_MAX_LEN) || (w_len[1:0] != 2'b00);
    assign w_last    = (r_count == r_len - 16'd1);
    assign w_addr    = BASE_ADDR + ADDR_W'(r_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_SYNC;
            ST_SYNC:   if (w_xfer && in_data == SYNC_BYTE) w_next = ST_LEN_LO;
            ST_LEN_LO: if (w_xfer) w_next = ST_LEN_HI;
            ST_LEN_HI: begin
                if (w_xfer) begin
                    if (w_len_bad)           w_next = ST_ERR;
                    else if (w_len == 16'd0) w_next = ST_CSUM;
                    else                     w_next = ST_DATA;
                end
            end
            ST_DATA:   if (w_xfer && w_last) w_next = ST_CSUM;
            ST_CSUM:   if (w_xfer) w_next = (in_data == r_sum) ? ST_DONE : ST_ERR;
            ST_DONE:   w_next = ST_IDLE;
            ST_ERR:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // in_ready depends on state alone so the source never sees a combinational loop
    always_comb begin
        in_ready = 1'b0;
        w_wr_vld = 1'b0;
        case (r_state)
            ST_SYNC, ST_LEN_LO, ST_LEN_HI, ST_CSUM: in_ready = 1'b1;
            ST_DATA: begin
                in_ready = 1'b1;
                w_wr_vld = w_xfer;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_xfer && r_state == ST_LEN_LO) r_len_lo <= in_data;
        if (w_xfer && r_state == ST_LEN_HI) begin
            r_len   <= w_len;
            r_count <= 16'd0;
            r_sum   <= 8'd0;
        end else if (w_wr_vld) begin
            r_count <= r_count + 16'd1;
            r_sum   <= r_sum + in_data;
        end
    end

    // Status flags are sticky until the next accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_core_hold <= 1'b1;
        end else if (r_state == ST_IDLE && start) begin
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_core_hold <= 1'b1;
        end else if (w_next == ST_DONE) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_core_hold <= 1'b0;
        end else if (w_next == ST_ERR) begin
            r_busy <= 1'b0;
            r_err  <= 1'b1;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign core_hold = r_core_hold;

    loader_wr_stage #(
        .ADDR_W (ADDR_W)
    ) u_wr_stage (
        .clk     (clk),
        .rst     (rst),
        .i_vld   (w_wr_vld),
        .i_addr  (w_addr),
        .i_data  (in_data),
        .o_we    (we),
        .o_waddr (waddr),
        .o_wdata (wdata)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a frame-parsing reference model.
module tb_imem_loader;

    localparam int                ADDR_W    = 20;
    localparam int                MEM_BYTES = 100;
    localparam logic [ADDR_W-1:0] BASE      = '0;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  frm[$];
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    bit          exp_ok;
    logic [31:0] act_addr[$];
    logic [7:0]  act_data[$];

    imem_loader #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES),
        .BASE_ADDR (BASE),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            act_addr.push_back(32'(waddr));
            act_data.push_back(wdata);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // Reference: find sync, read LEN, validate, derive writes and checksum verdict
    task automatic model();
        int         i;
        int         len;
        logic [7:0] s;
        exp_addr.delete();
        exp_data.delete();
        exp_ok = 1'b0;
        i = 0;
        while (i < frm.size() && frm[i] != 8'hA5) i++;
        i++;
        len = int'(frm[i]) + 256 * int'(frm[i+1]);
        i += 2;
        if (len > MEM_BYTES || (len % 4) != 0) return;
        s = 8'd0;
        for (int k = 0; k < len; k++) begin
            exp_addr.push_back(32'(BASE) + 32'(k));
            exp_data.push_back(frm[i+k]);
            s = s + frm[i+k];
        end
        exp_ok = (frm[i+len] == s);
    endtask

    task automatic build(input int noise, input int len, input bit hdr_only, input bit bad_csum);
        logic [7:0] s;
        logic [7:0] x;
        s = 8'd0;
        frm.delete();
        repeat (noise) begin
            do x = 8'($urandom); while (x == 8'hA5);
            frm.push_back(x);
        end
        frm.push_back(8'hA5);
        frm.push_back(8'(len));
        frm.push_back(8'(len >> 8));
        if (!hdr_only) begin
            for (int k = 0; k < len; k++) begin
                x = 8'($urandom);
                s = s + x;
                frm.push_back(x);
            end
            frm.push_back(bad_csum ? s + 8'd1 : s);
        end
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input int mode);
        int i;
        int cyc;
        bit v;
        i = 0;
        cyc = 0;
        while (i < b.size() && cyc < 4000) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = b[i];
            if (v && in_ready) i++;
            cyc++;
        end
        if (i < b.size()) chk("send_timeout", 32'(i), 32'(b.size()));
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input int mode, input int start_at, input bit poke_done);
        logic [7:0] head[$];
        logic [7:0] tail[$];
        model();
        act_addr.delete();
        act_data.delete();
        do_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
        chk("err_cleared", 32'(err), 32'd0);
        chk("hold_at_start", 32'(core_hold), 32'd1);
        if (start_at > 0) begin
            head = frm[0:start_at-1];
            tail = frm[start_at:$];
            send_bytes(head, mode);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("busy_start_ignored", 32'(busy), 32'd1);
            chk("ready_start_ignored", 32'(in_ready), 32'd1);
            send_bytes(tail, mode);
        end else begin
            send_bytes(frm, mode);
        end
        chk("done", 32'(done), 32'(exp_ok));
        chk("err", 32'(err), 32'(!exp_ok));
        chk("core_hold", 32'(core_hold), 32'(!exp_ok));
        chk("busy_end", 32'(busy), 32'd0);
        start = poke_done;
        @(negedge clk);
        start = 1'b0;
        chk("idle_ready", 32'(in_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("sticky_done", 32'(done), 32'(exp_ok));
        chk("n_writes", 32'(act_addr.size()), 32'(exp_addr.size()));
        for (int k = 0; k < exp_addr.size() && k < act_addr.size(); k++) begin
            chk("waddr", act_addr[k], exp_addr[k]);
            chk("wdata", 32'(act_data[k]), 32'(exp_data[k]));
        end
    endtask

    initial begin
        int len;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_core_hold", 32'(core_hold), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // nominal load, with a start pulse landing on the DONE cycle
        frm = '{8'hA5, 8'h08, 8'h00, 8'h13, 8'h02, 8'hA0, 8'h00,
                8'h63, 8'h00, 8'h04, 8'h02, 8'h1E};
        run_frame(0, 0, 1'b1);
        chk("t1_ok", 32'(exp_ok), 32'd1);

        frm[11] = 8'h1F;
        run_frame(0, 0, 1'b0);

        frm = '{8'hA5, 8'h66, 8'h00};
        run_frame(0, 0, 1'b0);
        frm = '{8'hA5, 8'h06, 8'h00};
        run_frame(0, 0, 1'b0);

        // noise ahead of sync, in_valid toggling
        build(0, 16, 1'b0, 1'b0);
        frm.push_front(8'hFF);
        frm.push_front(8'h00);
        run_frame(1, 0, 1'b0);

        // reset in the middle of the payload
        do_start();
        frm = '{8'hA5, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33};
        send_bytes(frm, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_we", 32'(we), 32'd0);
        chk("mid_rst_waddr", 32'(waddr), 32'd0);
        chk("mid_rst_wdata", 32'(wdata), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_hold", 32'(core_hold), 32'd1);
        build(0, 4, 1'b0, 1'b0);
        run_frame(0, 0, 1'b0);

        // zero length with a start pulse during LEN_LO
        frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame(0, 1, 1'b0);

        build(1, 100, 1'b0, 1'b0);
        run_frame(2, 0, 1'b0);
        build(0, 104, 1'b1, 1'b0);
        run_frame(0, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                do len = $urandom_range(1, 400); while (len <= MEM_BYTES && (len % 4) == 0);
                build($urandom_range(0, 3), len, 1'b1, 1'b0);
            end else begin
                build($urandom_range(0, 3), 4 * $urandom_range(0, 25), 1'b0,
                      ($urandom_range(0, 3) == 0));
            end
            run_frame($urandom_range(0, 2), 0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader. It is the write side of the byte-addressed, little-endian instruction memory that the single-cycle RV32I core reads combinationally.
- Receives a framed byte stream over a valid/ready handshake and issues one byte-write per payload byte into instruction memory.
- Holds the core in reset until a frame has loaded and its checksum passes.
- Sits between the host byte link (UART receiver or testbench) and the instruction memory write port.

Parameters:
- ADDR_W, 20, byte-address width; matches the instruction memory address port.
- MEM_BYTES, 100, instruction memory capacity in bytes; largest accepted payload length.
- BASE_ADDR, 0, byte address of the first payload byte.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that arms the loader; ignored while busy.
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- we  out  1  instruction memory byte write enable.
- waddr  out  ADDR_W  byte write address.
- wdata  out  8  byte write data.
- core_hold  out  1  keeps the core and its PC in reset.
- busy  out  1  a frame is in progress.
- done  out  1  last load succeeded; sticky.
- err  out  1  last load failed; sticky.

Behaviour:
- Reset values: state IDLE; in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0. core_hold=1, so the core never runs uninitialised memory.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, LEN payload bytes, CSUM.
  - LEN is a 16-bit byte count.
  - CSUM is the 8-bit sum, mod 256, of the payload bytes.
- Transfer rule: a byte transfers on a cycle where in_valid && in_ready. in_ready is a function of state only, never of in_valid.
- State IDLE: in_ready=0. On start, go to SYNC and set busy=1, core_hold=1, done=0, err=0.
- State SYNC: in_ready=1. A transfer equal to SYNC_BYTE moves to LEN_LO. Any other byte is discarded and the state stays in SYNC.
- State LEN_LO: capture the low length byte, then go to LEN_HI.
- State LEN_HI: capture the high length byte and check the length.
  - If LEN > MEM_BYTES or LEN[1:0] != 0, go to ERR.
  - If LEN == 0, go to CSUM.
  - Otherwise go to DATA with byte counter=0 and sum=0.
- State DATA, on each transfer:
  - Registered write: the next cycle has we=1, waddr=BASE_ADDR+count, wdata=byte.
  - count increments and sum += byte (8-bit wrap).
  - After byte LEN-1, go to CSUM.
  - we is a single-cycle pulse per byte. Back-to-back transfers give we high on consecutive cycles.
- State CSUM: on transfer, a byte equal to sum goes to DONE, otherwise to ERR.
  - The final DATA write is issued in the CSUM cycle, even if CSUM transfers the same cycle.
- State DONE (one cycle): done=1, busy=0, core_hold=0, then go to IDLE. done stays high until the next accepted start.
- State ERR (one cycle): err=1, busy=0, core_hold stays 1, then go to IDLE. err stays high until the next accepted start.
- start while busy=1 is ignored.
- start in the same cycle as the DONE/ERR cycle is ignored; it is honoured from IDLE.
- Address arithmetic: waddr is ADDR_W bits. count is 16 bits, zero-extended before the add. No wrap occurs, because LEN <= MEM_BYTES is enforced.
- Reset at any point, including mid-DATA, returns to the reset values. Partially written memory is not rolled back, and core_hold=1 guards it.
- A byte presented while in_ready=0 is not consumed; the source must hold it.

Decomposition:
- Package imem_loader_pkg: state enumeration (IDLE, SYNC, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR) and the SYNC_BYTE constant.
- One natural sub-module, loader_wr_stage: the one-stage byte-write register producing we/waddr/wdata.
- Everything else is the FSM plus counter and sum registers in the top.

Test Plan:
1. Nominal load. Stimulus: start; bytes A5 08 00 13 02 A0 00 63 00 04 02 CSUM=0x1E. Response: eight writes at addresses 0..7 with data 13 02 A0 00 63 00 04 02; done=1, err=0, core_hold falls one cycle after the CSUM transfer.
2. Checksum fault. Stimulus: same frame as test 1 with CSUM=0x1F. Response: all eight writes still occur; err=1, done=0, core_hold stays 1.
3. Length rejection. Stimulus: LEN=0x0066 (102), then separately LEN=0x0006. Response: err=1 after LEN_HI in both cases; no we pulse.
4. Noise and backpressure. Stimulus: bytes 00 FF before A5; in_valid toggles every other cycle during DATA. Response: leading bytes dropped; writes land at consecutive addresses with no gaps or duplicates.
5. Reset mid-frame. Stimulus: assert rst after 3 payload bytes; then start with a fresh LEN=4 frame. Response: all outputs at reset values; new frame writes addresses 0..3 and done=1.
6. Zero length and start while busy. Stimulus: start, A5 00 00 00; also a second start pulse during LEN_LO. Response: done=1, no writes; second start has no effect.
